restoring_divider: RTL

//   Iterative restoring divider, one quotient bit per clock, signed or unsigned per operation.
//   It is the inverse companion of the team's multiplier blocks and uses the same WIDTH-bit

---
 rtl/restoring_divider.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : restoring_divider
// Brief    : Iterative restoring divider, one quotient bit per clock, signed or
//            unsigned per operation, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_raw_dvd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dbz;

    logic             w_dvd_neg;
    logic             w_dsr_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dsr_abs;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dsr_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_abs = w_dvd_neg ? (-dividend) : dividend;
    assign w_dsr_abs = w_dsr_neg ? (-divisor)  : divisor;

    // The stored remainder is always below the divisor, so WIDTH bits hold it;
    // the shifted working value needs WIDTH+1. For a nonzero divisor the top bit
    // of the WIDTH+1-bit difference is exactly the borrow.
    assign w_rem_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, r_dsr};
    assign w_ge        = ~w_diff[WIDTH];
    assign w_rem_next  = w_ge ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_q_next    = {r_q[WIDTH-2:0], w_ge};
    assign w_last      = (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_CALC;
            S_CALC:  if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_raw_dvd   <= '0;
            r_cnt       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dbz       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_dvd     <= w_dvd_abs;
                        r_dsr     <= w_dsr_abs;
                        r_sign_q  <= w_dvd_neg ^ w_dsr_neg;
                        r_sign_r  <= w_dvd_neg;
                        r_dbz     <= (divisor == '0);
                        r_raw_dvd <= dividend;
                        r_rem     <= '0;
                        r_q       <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        if (r_dbz) begin
                            quotient    <= '1;
                            remainder   <= r_raw_dvd;
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= r_sign_q ? (-w_q_next)   : w_q_next;
                            remainder   <= r_sign_r ? (-w_rem_next) : w_rem_next;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
